// File: rtl/traffic_pkg.sv
// Shared types and constants for the intersection phase controller.
// Direction order N, E, S, W is also the service order.
package traffic_pkg;

  typedef enum logic [1:0] {
    ST_ALL_RED = 2'd0,
    ST_SELECT  = 2'd1,
    ST_GREEN   = 2'd2,
    ST_YELLOW  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    DIR_N = 2'd0,
    DIR_E = 2'd1,
    DIR_S = 2'd2,
    DIR_W = 2'd3
  } dir_t;

  localparam logic [2:0] LT_RED = 3'b100;
  localparam logic [2:0] LT_YEL = 3'b010;
  localparam logic [2:0] LT_GRN = 3'b001;

  function automatic logic [3:0] dir_onehot(input logic [1:0] d);
    dir_onehot = 4'b0001 << d;
  endfunction

  // Service order wraps W back to N through natural 2-bit overflow.
  function automatic logic [1:0] dir_next(input logic [1:0] d);
    dir_next = d + 2'd1;
  endfunction

endpackage

// File: rtl/green_time_calc.sv
// Converts a direction's moving-average count into its green duration in ticks,
// scaled by GSHIFT and clamped to MAX_GREEN.
module green_time_calc
  import traffic_pkg::*;
#(
  parameter int MIN_GREEN = 5,
  parameter int MAX_GREEN = 40,
  parameter int GSHIFT    = 1
) (
  input  logic [7:0] avg,
  output logic [7:0] green_ticks
);

  localparam logic [8:0] MIN_G9 = 9'(MIN_GREEN);
  localparam logic [8:0] MAX_G9 = 9'(MAX_GREEN);

  logic [7:0] scaled_s;
  logic [8:0] sum_s;

  // Ninth bit keeps MIN_GREEN + scaled average from wrapping before the clamp.
  always_comb begin
    scaled_s = avg >> GSHIFT;
    sum_s    = MIN_G9 + {1'b0, scaled_s};
    if (sum_s > MAX_G9) begin
      green_ticks = MAX_G9[7:0];
    end else begin
      green_ticks = sum_s[7:0];
    end
  end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Four-way signal sequencer: N, E, S, W in turn, green time from each sensor's
// average, one-clock sample strobe to a direction's sensor when it is done.
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int MIN_GREEN = 5,
  parameter int MAX_GREEN = 40,
  parameter int YELLOW_T  = 3,
  parameter int ALL_RED_T = 2,
  parameter int GSHIFT    = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic [7:0] avg_n,
  input  logic [7:0] avg_e,
  input  logic [7:0] avg_s,
  input  logic [7:0] avg_w,
  output logic [2:0] light_n,
  output logic [2:0] light_e,
  output logic [2:0] light_s,
  output logic [2:0] light_w,
  output logic [3:0] sample_req,
  output logic [1:0] cur_dir,
  output logic [7:0] phase_timer
);

  localparam logic [7:0] YELLOW_TICKS  = 8'(YELLOW_T);
  localparam logic [7:0] ALL_RED_TICKS = 8'(ALL_RED_T);

  state_t           state_r, state_nx_s;
  logic [1:0]       cur_dir_r, dir_nx_s;
  logic [7:0]       phase_timer_r, timer_nx_s, timer_dec_s;
  logic [1:0]       skip_cnt_r, skip_nx_s;
  logic [3:0]       sample_req_r, req_nx_s;
  logic [3:0][2:0]  lamp_r, lamp_nx_s;
  logic [7:0]       avg_sel_s;
  logic [7:0]       green_ticks_s;
  logic             expire_s;

  // Average of the direction currently under consideration.
  always_comb begin
    case (cur_dir_r)
      DIR_N:   avg_sel_s = avg_n;
      DIR_E:   avg_sel_s = avg_e;
      DIR_S:   avg_sel_s = avg_s;
      DIR_W:   avg_sel_s = avg_w;
      default: avg_sel_s = avg_w;
    endcase
  end

  green_time_calc #(
    .MIN_GREEN (MIN_GREEN),
    .MAX_GREEN (MAX_GREEN),
    .GSHIFT    (GSHIFT)
  ) u_green_time_calc (
    .avg         (avg_sel_s),
    .green_ticks (green_ticks_s)
  );

  // A timed state ends on the tick that finds one tick left.
  always_comb begin
    expire_s = tick && (phase_timer_r <= 8'd1);
    if (tick) begin
      timer_dec_s = phase_timer_r - 8'd1;
    end else begin
      timer_dec_s = phase_timer_r;
    end
  end

  // Next-state, timer, direction and strobe logic.
  always_comb begin
    state_nx_s = state_r;
    dir_nx_s   = cur_dir_r;
    timer_nx_s = phase_timer_r;
    skip_nx_s  = skip_cnt_r;
    req_nx_s   = 4'b0000;
    case (state_r)
      ST_ALL_RED: begin
        if (expire_s) begin
          state_nx_s = ST_SELECT;
          dir_nx_s   = dir_next(cur_dir_r);
        end else begin
          timer_nx_s = timer_dec_s;
        end
      end
      ST_SELECT: begin
        // Empty approaches are passed over (at most three in a row) but still sampled.
        if ((avg_sel_s == 8'd0) && (skip_cnt_r != 2'd3)) begin
          req_nx_s  = dir_onehot(cur_dir_r);
          dir_nx_s  = dir_next(cur_dir_r);
          skip_nx_s = skip_cnt_r + 2'd1;
        end else begin
          state_nx_s = ST_GREEN;
          timer_nx_s = green_ticks_s;
          skip_nx_s  = 2'd0;
        end
      end
      ST_GREEN: begin
        if (expire_s) begin
          state_nx_s = ST_YELLOW;
          timer_nx_s = YELLOW_TICKS;
          req_nx_s   = dir_onehot(cur_dir_r);
        end else begin
          timer_nx_s = timer_dec_s;
        end
      end
      ST_YELLOW: begin
        if (expire_s) begin
          state_nx_s = ST_ALL_RED;
          timer_nx_s = ALL_RED_TICKS;
        end else begin
          timer_nx_s = timer_dec_s;
        end
      end
      default: begin
        state_nx_s = ST_ALL_RED;
        dir_nx_s   = DIR_W;
        timer_nx_s = ALL_RED_TICKS;
        skip_nx_s  = 2'd0;
      end
    endcase
  end

  // Lamp pattern for the state being entered, so lamps switch on the transition edge.
  always_comb begin
    lamp_nx_s = {4{LT_RED}};
    case (state_nx_s)
      ST_GREEN:  lamp_nx_s[dir_nx_s] = LT_GRN;
      ST_YELLOW: lamp_nx_s[dir_nx_s] = LT_YEL;
      default:   lamp_nx_s = {4{LT_RED}};
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= ST_ALL_RED;
      cur_dir_r     <= DIR_W;
      phase_timer_r <= ALL_RED_TICKS;
      skip_cnt_r    <= 2'd0;
      sample_req_r  <= 4'b0000;
      lamp_r        <= {4{LT_RED}};
    end else begin
      state_r       <= state_nx_s;
      cur_dir_r     <= dir_nx_s;
      phase_timer_r <= timer_nx_s;
      skip_cnt_r    <= skip_nx_s;
      sample_req_r  <= req_nx_s;
      lamp_r        <= lamp_nx_s;
    end
  end

  assign light_n     = lamp_r[0];
  assign light_e     = lamp_r[1];
  assign light_s     = lamp_r[2];
  assign light_w     = lamp_r[3];
  assign sample_req  = sample_req_r;
  assign cur_dir     = cur_dir_r;
  assign phase_timer = phase_timer_r;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Bench for traffic_phase_ctrl: a timeline model of the signal sequence checked
// every cycle, plus hand-computed checkpoints and a green_time_calc table.
module tb_traffic_phase_ctrl;
  import traffic_pkg::*;

  localparam int MIN_G = 5;
  localparam int MAX_G = 40;
  localparam int YEL_T = 3;
  localparam int AR_T  = 2;
  localparam int GSH   = 1;

  logic       clk = 1'b0;
  logic       reset, tick;
  logic [7:0] avg_n, avg_e, avg_s, avg_w;
  logic [2:0] light_n, light_e, light_s, light_w;
  logic [3:0] sample_req;
  logic [1:0] cur_dir;
  logic [7:0] phase_timer;
  logic [7:0] gt_avg, gt_ticks;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  int         m_dir, m_timer;
  logic [3:0] m_req;
  logic [2:0] m_lamp [4];
  bit         m_rst, m_tick;

  logic [7:0] ut_in  [9] = '{8'd0, 8'd1, 8'd3, 8'd8, 8'd20, 8'd69, 8'd70, 8'd200, 8'd255};
  int         ut_exp [9] = '{5, 5, 6, 9, 15, 39, 40, 40, 40};

  always #5 clk = ~clk;

  traffic_phase_ctrl #(
    .MIN_GREEN (MIN_G), .MAX_GREEN (MAX_G), .YELLOW_T (YEL_T),
    .ALL_RED_T (AR_T),  .GSHIFT    (GSH)
  ) dut (
    .clk (clk), .reset (reset), .tick (tick),
    .avg_n (avg_n), .avg_e (avg_e), .avg_s (avg_s), .avg_w (avg_w),
    .light_n (light_n), .light_e (light_e), .light_s (light_s), .light_w (light_w),
    .sample_req (sample_req), .cur_dir (cur_dir), .phase_timer (phase_timer)
  );

  green_time_calc #(.MIN_GREEN (MIN_G), .MAX_GREEN (MAX_G), .GSHIFT (GSH)) u_gtc (
    .avg (gt_avg), .green_ticks (gt_ticks)
  );

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic bound_expired(input string name, input int budget);
    n_tests++;
    n_fail++;
    $display("FAIL %s: condition not reached within %0d steps", name, budget);
  endtask

  function automatic logic [7:0] avg_of(input int d);
    case (d)
      0:       avg_of = avg_n;
      1:       avg_of = avg_e;
      2:       avg_of = avg_s;
      default: avg_of = avg_w;
    endcase
  endfunction

  function automatic logic [2:0] lamp_of(input int d);
    case (d)
      0:       lamp_of = light_n;
      1:       lamp_of = light_e;
      2:       lamp_of = light_s;
      default: lamp_of = light_w;
    endcase
  endfunction

  // ---------------- timeline model ----------------
  task automatic m_reset();
    m_dir   = 3;
    m_timer = AR_T;
    m_req   = 4'b0000;
    for (int i = 0; i < 4; i++) m_lamp[i] = LT_RED;
  endtask

  task automatic m_edge();
    @(posedge clk);
    m_rst  = reset;
    m_tick = tick;
    m_req  = 4'b0000;
  endtask

  // Count down the current timed interval; returns at the edge that ends it.
  task automatic m_timed(output bit aborted);
    bit done = 1'b0;
    aborted = 1'b0;
    while (!done) begin
      m_edge();
      if (m_rst) begin
        aborted = 1'b1;
        done    = 1'b1;
      end else if (m_tick) begin
        if (m_timer == 1) done = 1'b1;
        else m_timer = m_timer - 1;
      end
    end
  endtask

  initial begin : model
    bit ab;
    bit served;
    int skips, g;
    m_reset();
    forever begin
      m_timed(ab);
      if (!ab) begin
        m_dir  = (m_dir + 1) % 4;
        skips  = 0;
        served = 1'b0;
        while (!served && !ab) begin
          m_edge();
          if (m_rst) ab = 1'b1;
          else if (avg_of(m_dir) == 8'd0 && skips < 3) begin
            m_req = 4'(1 << m_dir);
            m_dir = (m_dir + 1) % 4;
            skips++;
          end else begin
            g = MIN_G + (int'(avg_of(m_dir)) >> GSH);
            if (g > MAX_G) g = MAX_G;
            m_timer = g;
            m_lamp[m_dir] = LT_GRN;
            served = 1'b1;
          end
        end
      end
      if (!ab) begin
        m_timed(ab);
        if (!ab) begin
          m_lamp[m_dir] = LT_YEL;
          m_req   = 4'(1 << m_dir);
          m_timer = YEL_T;
        end
      end
      if (!ab) begin
        m_timed(ab);
        if (!ab) begin
          m_lamp[m_dir] = LT_RED;
          m_timer = AR_T;
        end
      end
      if (ab) m_reset();
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("model light_n", int'(light_n), int'(m_lamp[0]));
      check("model light_e", int'(light_e), int'(m_lamp[1]));
      check("model light_s", int'(light_s), int'(m_lamp[2]));
      check("model light_w", int'(light_w), int'(m_lamp[3]));
      check("model sample_req", int'(sample_req), int'(m_req));
      check("model cur_dir", int'(cur_dir), m_dir);
      check("model phase_timer", int'(phase_timer), m_timer);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick_once();
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_green(input int d, input int budget);
    int n = 0;
    while (lamp_of(d) != LT_GRN && n < budget) begin
      tick_once();
      n++;
    end
    if (lamp_of(d) != LT_GRN) bound_expired($sformatf("wait_green dir %0d", d), budget);
  endtask

  task automatic wait_timer(input int v, input int budget);
    int n = 0;
    while (int'(phase_timer) != v && n < budget) begin
      tick_once();
      n++;
    end
    if (int'(phase_timer) != v) bound_expired($sformatf("wait_timer %0d", v), budget);
  endtask

  task automatic run_until_req(input logic [3:0] want, input int budget);
    int n = 0;
    bit hit = 1'b0;
    while (!hit && n < budget) begin
      tick = ~tick;
      @(negedge clk);
      n++;
      hit = (sample_req == want);
    end
    tick = 1'b0;
    if (!hit) bound_expired($sformatf("run_until_req %b", want), budget);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset = 1'b1; tick = 1'b0; gt_avg = 8'd0;
    avg_n = 8'd20; avg_e = 8'd200; avg_s = 8'd8; avg_w = 8'd10;

    for (int i = 0; i < 9; i++) begin
      gt_avg = ut_in[i];
      #1;
      check($sformatf("green_time_calc(%0d)", ut_in[i]), int'(gt_ticks), ut_exp[i]);
    end

    repeat (2) @(negedge clk);
    reset  = 1'b0;
    chk_en = 1'b1;
    check("reset light_n", int'(light_n), 4);
    check("reset light_e", int'(light_e), 4);
    check("reset light_s", int'(light_s), 4);
    check("reset light_w", int'(light_w), 4);
    check("reset sample_req", int'(sample_req), 0);
    check("reset phase_timer", int'(phase_timer), 2);
    check("reset cur_dir", int'(cur_dir), 3);

    // Two ticks of all-red, then one SELECT clock.
    tick = 1'b1;
    repeat (2) @(negedge clk);
    tick = 1'b0;
    @(negedge clk);
    check("first green light_n", int'(light_n), 1);
    check("first green phase_timer", int'(phase_timer), 15);
    check("first green cur_dir", int'(cur_dir), 0);

    repeat (14) tick_once();
    check("north last tick timer", int'(phase_timer), 1);
    check("north last tick light", int'(light_n), 1);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    check("north strobe", int'(sample_req), 1);
    check("north yellow", int'(light_n), 2);
    check("north yellow timer", int'(phase_timer), 3);
    @(negedge clk);
    check("north strobe width", int'(sample_req), 0);

    wait_green(1, 40);
    check("clamp east timer", int'(phase_timer), 40);
    avg_e = 8'd0;                      // must not shorten the green already granted
    wait_green(3, 200);
    check("west green timer", int'(phase_timer), 10);
    wait_green(0, 100);
    check("north second green timer", int'(phase_timer), 15);

    run_until_req(4'b0010, 100);
    check("skip strobe east", int'(sample_req), 2);
    check("skip east stays red", int'(light_e), 4);
    check("skip cur_dir", int'(cur_dir), 2);
    @(negedge clk);
    check("skip south green", int'(light_s), 1);
    check("skip south timer", int'(phase_timer), 9);
    check("skip strobe width", int'(sample_req), 0);

    wait_green(3, 100);
    wait_green(0, 100);
    avg_n = 8'd0; avg_e = 8'd0; avg_s = 8'd0; avg_w = 8'd0;
    run_until_req(4'b0010, 100);
    @(negedge clk);
    check("all-zero strobe south", int'(sample_req), 4);
    @(negedge clk);
    check("all-zero strobe west", int'(sample_req), 8);
    check("all-zero cur_dir", int'(cur_dir), 0);
    @(negedge clk);
    check("all-zero north green", int'(light_n), 1);
    check("all-zero north timer", int'(phase_timer), 5);
    check("all-zero strobe clear", int'(sample_req), 0);

    avg_e = 8'd20;
    wait_green(1, 100);
    check("east green timer", int'(phase_timer), 15);
    wait_timer(7, 20);
    reset = 1'b1;
    tick  = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    tick  = 1'b0;
    check("mid-green reset light_e", int'(light_e), 4);
    check("mid-green reset timer", int'(phase_timer), 2);
    check("mid-green reset cur_dir", int'(cur_dir), 3);
    check("mid-green reset strobe", int'(sample_req), 0);
    @(negedge clk);
    check("mid-green reset no late strobe", int'(sample_req), 0);

    avg_n = 8'd20;
    wait_green(0, 20);
    check("post-reset north timer", int'(phase_timer), 15);
    repeat (6) tick_once();

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1);
  end

endmodule
